sdrc_req_split: RTL and testbench

// - Upstream of the buswidth converter. Takes one application request of any length.
// - Issues it as a sequence of chunk requests, each of which:
//   - fits the converter's 8-bit transfer counters for the current SDR width;
//   - never crosses a 2^BND_W-word address boundary.
// - Write/read data paths bypass this block; only the request/ack handshake passes through it.

---
 rtl/sdrc_pkg.sv | 32 +++
 rtl/sdrc_req_split_if.sv | 37 +++
 rtl/sdrc_chunk_calc.sv | 31 +++
 rtl/sdrc_req_split.sv | 105 ++++++++++
 tb/tb_sdrc_req_split.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sdrc_pkg.sv
// rtl/sdrc_pkg.sv - shared types and constants for the request splitter
// Purpose: FSM state encoding, SDR width codes and per-width chunk caps.
// Ports: none (package).
package sdrc_pkg;

  typedef enum logic [1:0] {
    SPLIT_IDLE  = 2'd0,
    SPLIT_CALC  = 2'd1,
    SPLIT_ISSUE = 2'd2,
    SPLIT_DONE  = 2'd3
  } split_state_t;

  localparam logic [1:0] SDR_W32 = 2'b00;
  localparam logic [1:0] SDR_W16 = 2'b01;
  localparam logic [1:0] SDR_W8  = 2'b10;

  // Converter transfer-counter limits, in SDR units, per width.
  localparam int CAP_SDR_W32 = 255;
  localparam int CAP_SDR_W16 = 127;
  localparam int CAP_SDR_W8  = 63;

  // Word cap for one chunk. Narrow widths halve the SDR-unit limit so the
  // converter's doubled/quadrupled beat count still fits in 8 bits.
  function automatic int cap_words(input logic [1:0] width, input int max_len);
    int c;
    if (width[1])      c = CAP_SDR_W8 >> 1;
    else if (width[0]) c = CAP_SDR_W16 >> 1;
    else               c = CAP_SDR_W32;
    return (max_len < c) ? max_len : c;
  endfunction

endpackage

// File: rtl/sdrc_req_split_if.sv
// rtl/sdrc_req_split_if.sv - request/ack bus between application, splitter and converter
// Purpose: groups the upstream usr_* request, the downstream app_* chunk request
//          and the SDR width select.
// Modports: master = application/converter side, slave = splitter.
interface sdrc_req_split_if #(
  parameter int APP_AW = 30,
  parameter int APP_RW = 9
);
  logic [1:0]        sdr_width;
  logic              usr_req;
  logic [APP_AW-1:0] usr_req_addr;
  logic [APP_RW-1:0] usr_req_len;
  logic              usr_req_wr_n;
  logic              usr_req_dma_last;
  logic              usr_req_ack;
  logic              usr_busy;
  logic              app_sdr_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [APP_RW-1:0] app_req_len;
  logic              app_req_wr_n;
  logic              app_req_dma_last;
  logic              app_req_ack;

  modport master (
    output sdr_width, usr_req, usr_req_addr, usr_req_len, usr_req_wr_n,
           usr_req_dma_last, app_req_ack,
    input  usr_req_ack, usr_busy, app_sdr_req, app_req_addr, app_req_len,
           app_req_wr_n, app_req_dma_last
  );

  modport slave (
    input  sdr_width, usr_req, usr_req_addr, usr_req_len, usr_req_wr_n,
           usr_req_dma_last, app_req_ack,
    output usr_req_ack, usr_busy, app_sdr_req, app_req_addr, app_req_len,
           app_req_wr_n, app_req_dma_last
  );
endinterface

// File: rtl/sdrc_chunk_calc.sv
// rtl/sdrc_chunk_calc.sv - combinational chunk size: min(remaining, width cap, boundary room)
// Ports: rem     in  remaining words of the request
//        addr_lo in  low BND_W bits of the current word address
//        width   in  latched SDR width code
//        chunk   out words to issue in the next chunk
module sdrc_chunk_calc
  import sdrc_pkg::*;
#(
  parameter int APP_RW  = 9,
  parameter int MAX_LEN = 128,
  parameter int BND_W   = 8
) (
  input  logic [APP_RW-1:0] rem,
  input  logic [BND_W-1:0]  addr_lo,
  input  logic [1:0]        width,
  output logic [APP_RW-1:0] chunk
);
  // One extra bit: a boundary-aligned address has a full 2^BND_W words of room.
  logic [APP_RW:0] room;
  logic [APP_RW:0] cap;
  logic [APP_RW:0] m;

  always_comb begin
    room = ((APP_RW+1)'(1) << BND_W) - (APP_RW+1)'(addr_lo);
    cap  = (APP_RW+1)'(cap_words(width, MAX_LEN));
    m    = {1'b0, rem};
    if (cap < m)  m = cap;
    if (room < m) m = room;
    chunk = m[APP_RW-1:0];
  end
endmodule

// File: rtl/sdrc_req_split.sv
// rtl/sdrc_req_split.sv - splits one application request into converter-sized chunk requests
// Ports: clk, reset_n (synchronous, active-low)
//        bus.slave: usr_* request in / usr_req_ack, usr_busy out,
//                   app_* chunk request out / app_req_ack in, sdr_width in
module sdrc_req_split
  import sdrc_pkg::*;
#(
  parameter int APP_AW  = 30,
  parameter int APP_RW  = 9,
  parameter int MAX_LEN = 128,
  parameter int BND_W   = 8
) (
  input logic            clk,
  input logic            reset_n,
  sdrc_req_split_if.slave bus
);
  split_state_t      state_q, state_d;
  logic [APP_AW-1:0] addr_q;
  logic [APP_RW-1:0] rem_q;
  logic [APP_RW-1:0] chunk_q;
  logic [APP_RW-1:0] chunk_d;
  logic              wr_n_q;
  logic              dma_last_q;
  logic [1:0]        width_q;

  sdrc_chunk_calc #(
    .APP_RW (APP_RW),
    .MAX_LEN(MAX_LEN),
    .BND_W  (BND_W)
  ) u_chunk_calc (
    .rem    (rem_q),
    .addr_lo(addr_q[BND_W-1:0]),
    .width  (width_q),
    .chunk  (chunk_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= SPLIT_IDLE;
    else          state_q <= state_d;
  end

  // Inputs are only sampled in IDLE, so mid-request changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      wr_n_q     <= 1'b1;
      dma_last_q <= 1'b0;
      width_q    <= SDR_W32;
    end else begin
      case (state_q)
        SPLIT_IDLE: begin
          if (bus.usr_req) begin
            addr_q     <= bus.usr_req_addr;
            rem_q      <= bus.usr_req_len;
            wr_n_q     <= bus.usr_req_wr_n;
            dma_last_q <= bus.usr_req_dma_last;
            width_q    <= bus.sdr_width;
          end
        end
        SPLIT_CALC: chunk_q <= chunk_d;
        SPLIT_ISSUE: begin
          if (bus.app_req_ack) begin
            addr_q <= addr_q + APP_AW'(chunk_q);
            rem_q  <= rem_q - chunk_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d              = state_q;
    bus.usr_req_ack      = 1'b0;
    bus.usr_busy         = 1'b1;
    bus.app_sdr_req      = 1'b0;
    bus.app_req_dma_last = 1'b0;
    case (state_q)
      SPLIT_IDLE: begin
        bus.usr_busy = 1'b0;
        if (bus.usr_req)
          state_d = (bus.usr_req_len == '0) ? SPLIT_DONE : SPLIT_CALC;
      end
      SPLIT_CALC: state_d = SPLIT_ISSUE;
      SPLIT_ISSUE: begin
        bus.app_sdr_req = 1'b1;
        // Final chunk is the one that consumes everything still remaining.
        bus.app_req_dma_last = dma_last_q && (rem_q == chunk_q);
        if (bus.app_req_ack)
          state_d = (rem_q == chunk_q) ? SPLIT_DONE : SPLIT_CALC;
      end
      SPLIT_DONE: begin
        bus.usr_req_ack = 1'b1;
        state_d         = SPLIT_IDLE;
      end
      default: state_d = SPLIT_IDLE;
    endcase
  end

  assign bus.app_req_addr = addr_q;
  assign bus.app_req_len  = chunk_q;
  assign bus.app_req_wr_n = wr_n_q;
endmodule

// File: tb/tb_sdrc_req_split.sv
// tb/tb_sdrc_req_split.sv - self-checking bench for sdrc_req_split
module tb_sdrc_req_split;
  localparam int AW = 30;
  localparam int RW = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdrc_req_split_if #(.APP_AW(AW), .APP_RW(RW)) bus ();

  sdrc_req_split #(
    .APP_AW(AW), .APP_RW(RW), .MAX_LEN(128), .BND_W(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [RW-1:0] len;
    logic          wr_n;
    logic          dma;
  } chunk_t;

  typedef struct packed {
    logic [1:0]         w;
    logic [AW-1:0]      addr;
    logic [RW-1:0]      len;
    logic               wr_n;
    logic               dma;
    logic [2:0]         n;
    logic [3:0][RW-1:0] cl;
  } vec_t;

  chunk_t exp_q[$];
  vec_t   vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] w, input logic [AW-1:0] addr, input logic [RW-1:0] len,
                         input logic wr_n, input logic dma, input int n,
                         input int l0, input int l1, input int l2, input int l3);
    vec_t v;
    v.w = w; v.addr = addr; v.len = len; v.wr_n = wr_n; v.dma = dma; v.n = 3'(n);
    v.cl[0] = RW'(l0); v.cl[1] = RW'(l1); v.cl[2] = RW'(l2); v.cl[3] = RW'(l3);
    vecs.push_back(v);
  endtask

  task automatic check_chunk(input chunk_t e);
    check("app_sdr_req",      64'(bus.app_sdr_req), 64'(1));
    check("app_req_addr",     64'(bus.app_req_addr), 64'(e.addr));
    check("app_req_len",      64'(bus.app_req_len), 64'(e.len));
    check("app_req_wr_n",     64'(bus.app_req_wr_n), 64'(e.wr_n));
    check("app_req_dma_last", 64'(bus.app_req_dma_last), 64'(e.dma));
  endtask

  // Pushes the expected chunks, drives the request and consumes chunks until usr_req_ack.
  // hold<0 picks a random ack delay; toggle disturbs sdr_width/usr_* while waiting.
  task automatic run_req(input vec_t v, input int hold, input bit toggle);
    logic [AW-1:0] a;
    chunk_t e;
    int cyc, d;
    bit done;
    a = v.addr;
    for (int i = 0; i < int'(v.n); i++) begin
      exp_q.push_back({a, v.cl[i], v.wr_n, v.dma && (i == int'(v.n) - 1)});
      a = a + AW'(v.cl[i]);
    end
    bus.sdr_width = v.w; bus.usr_req_addr = v.addr; bus.usr_req_len = v.len;
    bus.usr_req_wr_n = v.wr_n; bus.usr_req_dma_last = v.dma; bus.usr_req = 1'b1;
    @(negedge clk); cyc = 1; done = 1'b0;
    while (!done) begin
      if (bus.usr_req_ack) begin
        check("usr_ack_latency", 64'(cyc), 64'(1));
        check("pending_chunks", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        bus.usr_req = 1'b0;
        @(negedge clk);
        check("usr_ack_pulse", 64'(bus.usr_req_ack), 64'(0));
        check("busy_after_done", 64'(bus.usr_busy), 64'(0));
        done = 1'b1;
      end else if (bus.app_sdr_req) begin
        check("req_latency", 64'(cyc), 64'(2));
        check("chunk_queued", 64'(exp_q.size() > 0), 64'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_chunk(e);
        d = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check_chunk(e);
          if (toggle) begin
            bus.sdr_width = (i % 2 == 1) ? 2'b00 : 2'b01;
            bus.usr_req_addr = 30'h123; bus.usr_req_len = 9'd5;
            bus.usr_req_wr_n = ~v.wr_n; bus.usr_req_dma_last = ~v.dma;
          end
        end
        bus.app_req_ack = 1'b1;
        @(negedge clk);
        bus.app_req_ack = 1'b0;
        cyc = 1;
      end else if (cyc >= 40) begin
        check("timeout_waiting", 64'(cyc), 64'(0));
        exp_q.delete();
        bus.usr_req = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic wait_app_req(output int cyc);
    cyc = 1;
    while (!bus.app_sdr_req && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_app_req", 64'(bus.app_sdr_req), 64'(1));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vl;
    int   cyc, seen;
    bus.sdr_width = 2'b00; bus.usr_req = 1'b0; bus.usr_req_addr = '0; bus.usr_req_len = '0;
    bus.usr_req_wr_n = 1'b1; bus.usr_req_dma_last = 1'b0; bus.app_req_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_app_sdr_req",      64'(bus.app_sdr_req), 64'(0));
    check("rst_app_req_addr",     64'(bus.app_req_addr), 64'(0));
    check("rst_app_req_len",      64'(bus.app_req_len), 64'(0));
    check("rst_app_req_wr_n",     64'(bus.app_req_wr_n), 64'(1));
    check("rst_app_req_dma_last", 64'(bus.app_req_dma_last), 64'(0));
    check("rst_usr_req_ack",      64'(bus.usr_req_ack), 64'(0));
    check("rst_usr_busy",         64'(bus.usr_busy), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    //      width  addr          len  wr dma n  chunk lengths
    add_vec(2'b00, 30'h10,       8,   0, 1, 1, 8,   0,   0,   0);
    add_vec(2'b00, 30'hF8,       16,  0, 1, 2, 8,   8,   0,   0);
    add_vec(2'b10, 30'h0,        100, 1, 0, 4, 31,  31,  31,  7);
    add_vec(2'b01, 30'h55,       0,   0, 1, 0, 0,   0,   0,   0);
    add_vec(2'b00, 30'h0,        300, 1, 1, 3, 128, 128, 44,  0);
    add_vec(2'b01, 30'h3C0,      100, 0, 1, 3, 63,  1,   36,  0);
    add_vec(2'b00, 30'h3FFFFFFC, 8,   1, 1, 2, 4,   4,   0,   0);
    add_vec(2'b11, 30'h5,        3,   1, 0, 1, 3,   0,   0,   0);
    add_vec(2'b00, 30'h0,        511, 0, 1, 4, 128, 128, 128, 127);
    foreach (vecs[i]) run_req(vecs[i], -1, 1'b0);

    // Slow converter: ack held off 20 cycles while width and usr_* inputs churn.
    vecs.delete();
    add_vec(2'b10, 30'h0, 70, 0, 1, 3, 31, 31, 8, 0);
    run_req(vecs[0], 20, 1'b1);

    // New request held through usr_req_ack is taken only in the following IDLE cycle.
    bus.sdr_width = 2'b01; bus.usr_req_addr = 30'h7; bus.usr_req_len = 9'd0;
    bus.usr_req_wr_n = 1'b0; bus.usr_req_dma_last = 1'b0; bus.usr_req = 1'b1;
    @(negedge clk);
    check("b2b_zero_ack", 64'(bus.usr_req_ack), 64'(1));
    check("b2b_zero_no_req", 64'(bus.app_sdr_req), 64'(0));
    bus.sdr_width = 2'b00; bus.usr_req_addr = 30'h40; bus.usr_req_len = 9'd4;
    bus.usr_req_dma_last = 1'b1;
    @(negedge clk);
    check("b2b_idle_gap", 64'(bus.usr_busy), 64'(0));
    @(negedge clk);
    check("b2b_accepted", 64'(bus.usr_busy), 64'(1));
    check("b2b_calc_no_req", 64'(bus.app_sdr_req), 64'(0));
    @(negedge clk);
    check_chunk({30'h40, 9'd4, 1'b0, 1'b1});
    bus.app_req_ack = 1'b1;
    @(negedge clk);
    bus.app_req_ack = 1'b0;
    check("b2b_usr_ack", 64'(bus.usr_req_ack), 64'(1));
    bus.usr_req = 1'b0;
    @(negedge clk);

    // Reset during ISSUE of the second chunk abandons the request.
    bus.sdr_width = 2'b10; bus.usr_req_addr = 30'h0; bus.usr_req_len = 9'd100;
    bus.usr_req_wr_n = 1'b0; bus.usr_req_dma_last = 1'b1; bus.usr_req = 1'b1;
    @(negedge clk);
    wait_app_req(cyc);
    bus.app_req_ack = 1'b1;
    @(negedge clk);
    bus.app_req_ack = 1'b0;
    wait_app_req(cyc);
    check("rst_mid_chunk2_addr", 64'(bus.app_req_addr), 64'(31));
    reset_n = 1'b0; bus.usr_req = 1'b0;
    @(negedge clk);
    check("rstmid_app_sdr_req",      64'(bus.app_sdr_req), 64'(0));
    check("rstmid_app_req_addr",     64'(bus.app_req_addr), 64'(0));
    check("rstmid_app_req_len",      64'(bus.app_req_len), 64'(0));
    check("rstmid_app_req_wr_n",     64'(bus.app_req_wr_n), 64'(1));
    check("rstmid_app_req_dma_last", 64'(bus.app_req_dma_last), 64'(0));
    check("rstmid_usr_req_ack",      64'(bus.usr_req_ack), 64'(0));
    check("rstmid_usr_busy",         64'(bus.usr_busy), 64'(0));
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.usr_req_ack || bus.app_sdr_req || bus.usr_busy) seen++;
    end
    check("rstmid_quiet_after", 64'(seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
